motion_anomaly_engine: RTL and testbench

// - Parametrised successor to the 3-axis motion AI core. Streams NUM_CH signed channels

---
 rtl/motion_anomaly_engine.sv | 195 +++++++++++++++++++
 tb/tb_motion_anomaly_engine.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_anomaly_engine.sv
// motion_anomaly_engine: windowed motion classifier over NUM_CH signed channels.
// Each window of WIN_LEN accepted samples yields a saturating energy (sum of |x|),
// a saturating count of channel magnitudes above cfg_mag_thr, and a pattern/score.
// Running sums only; no sample storage. Single-shot or back-to-back windows.
// Optional build macro: MOTION_PEAK_EN adds per-window peak magnitude tracking;
// without it peak_mag is tied to 0 and the port list is unchanged.
module motion_anomaly_engine #(
  parameter int NUM_CH  = 3,
  parameter int DW      = 16,
  parameter int WIN_LEN = 100,
  parameter int ACC_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [NUM_CH*DW-1:0] s_data,
  input  logic [DW-1:0]        cfg_mag_thr,
  input  logic [ACC_W-1:0]     cfg_energy_thr,
  input  logic [ACC_W-1:0]     cfg_var_thr,
  output logic [1:0]           motion_pattern,
  output logic [7:0]           anomaly_score,
  output logic [ACC_W-1:0]     energy_out,
  output logic [ACC_W-1:0]     var_out,
  output logic [DW:0]          peak_mag,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CLASSIFY, S_RESULT} state_t;

  localparam int MAG_W = DW + 1;
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int SUM_W = MAG_W + CNT_W;
  // One bit wider than either addend so an overflow is visible before clamping.
  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam int IDX_W = $clog2(WIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);
  localparam logic [EXT_W-1:0] SAT_EXT  = {{(EXT_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               cont_q;
  logic [ACC_W-1:0]   acc_e_q, acc_v_q;
  logic [ACC_W-1:0]   acc_e_d, acc_v_d;
  logic [ACC_W-1:0]   energy_out_q, var_out_q;
  logic [1:0]         pattern_q;
  logic [7:0]         score_q;
  logic               done_q, busy_q;
  logic [SUM_W-1:0]   samp_sum;
  logic [CNT_W-1:0]   samp_cnt;
  logic [EXT_W-1:0]   e_sum_ext, v_sum_ext;
  logic               accept, win_clear;
`ifdef MOTION_PEAK_EN
  logic [MAG_W-1:0]   samp_peak;
  logic [MAG_W-1:0]   peak_q, peak_mag_q;
`endif

  // |x| in DW+1 bits so the most negative code maps to 2^(DW-1) without overflow.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [DW-1:0] x);
    logic [MAG_W-1:0] ext;
    ext = {x[DW-1], x};
    return x[DW-1] ? (~ext + MAG_W'(1)) : ext;
  endfunction

  assign s_ready   = (state_q == S_COLLECT);
  assign accept    = s_valid && s_ready;
  assign win_clear = ((state_q == S_IDLE) && start) || ((state_q == S_RESULT) && cont_q);

  // Per-sample statistics across all channels of the current input word.
  always_comb begin : sample_stats
    logic [MAG_W-1:0] m;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    m        = '0;
    samp_sum = '0;
    samp_cnt = '0;
`ifdef MOTION_PEAK_EN
    samp_peak = '0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      m        = abs_mag(s_data[c*DW +: DW]);
      samp_sum = samp_sum + SUM_W'(m);
      if (m > {1'b0, cfg_mag_thr}) samp_cnt = samp_cnt + CNT_W'(1);
`ifdef MOTION_PEAK_EN
      if (m > samp_peak) samp_peak = m;
`endif
    end
  end

  // Saturating next values of the window accumulators.
  always_comb begin
    e_sum_ext = EXT_W'(acc_e_q) + EXT_W'(samp_sum);
    v_sum_ext = EXT_W'(acc_v_q) + EXT_W'(samp_cnt);
    acc_e_d   = (e_sum_ext > SAT_EXT) ? '1 : e_sum_ext[ACC_W-1:0];
    acc_v_d   = (v_sum_ext > SAT_EXT) ? '1 : v_sum_ext[ACC_W-1:0];
  end

  // Window FSM with accumulators and registered result outputs; abort yields only to rst.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cont_q       <= 1'b0;
      acc_e_q      <= '0;
      acc_v_q      <= '0;
      energy_out_q <= '0;
      var_out_q    <= '0;
      pattern_q    <= 2'd0;
      score_q      <= 8'd0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        if (win_clear) begin
          acc_e_q <= '0;
          acc_v_q <= '0;
          idx_q   <= '0;
        end
        case (state_q)
          S_IDLE: if (start) begin
            state_q <= S_COLLECT;
            busy_q  <= 1'b1;
            cont_q  <= continuous;
          end
          S_COLLECT: if (accept) begin
            acc_e_q <= acc_e_d;
            acc_v_q <= acc_v_d;
            idx_q   <= idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) state_q <= S_CLASSIFY;
          end
          S_CLASSIFY: begin
            energy_out_q <= acc_e_q;
            var_out_q    <= acc_v_q;
            if (acc_e_q > cfg_energy_thr) begin
              pattern_q <= 2'd3;
              score_q   <= 8'd95;
            end else if (acc_v_q > cfg_var_thr) begin
              pattern_q <= 2'd2;
              score_q   <= 8'd70;
            end else begin
              pattern_q <= 2'd1;
              score_q   <= 8'd20;
            end
            done_q  <= 1'b1;
            state_q <= S_RESULT;
          end
          S_RESULT: begin
            if (cont_q) begin
              state_q <= S_COLLECT;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

`ifdef MOTION_PEAK_EN
  // Peak magnitude over the accepted samples of the window, published in CLASSIFY.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q     <= '0;
      peak_mag_q <= '0;
    end else if (!abort) begin
      if (win_clear) begin
        peak_q <= '0;
      end else if (accept && (samp_peak > peak_q)) begin
        peak_q <= samp_peak;
      end
      if (state_q == S_CLASSIFY) peak_mag_q <= peak_q;
    end
  end
  assign peak_mag = peak_mag_q;
`else
  assign peak_mag = '0;
`endif

  assign motion_pattern = pattern_q;
  assign anomaly_score  = score_q;
  assign energy_out     = energy_out_q;
  assign var_out        = var_out_q;
  assign done           = done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_motion_anomaly_engine.sv
// Self-checking bench for motion_anomaly_engine: directed corner windows plus
// randomized windows scored against a behavioural window model. A second instance
// with a 17-bit accumulator covers energy saturation.
module tb_motion_anomaly_engine;

  localparam int NUM_CH  = 3;
  localparam int DW      = 16;
  localparam int WIN_LEN = 4;
  localparam int ACC_W   = 32;
  localparam int ACC_S   = 17;

  logic                 clk = 1'b0;
  logic                 rst, start, continuous, abort, s_valid;
  logic [NUM_CH*DW-1:0] s_data;
  logic [DW-1:0]        cfg_mag_thr;
  logic [ACC_W-1:0]     cfg_energy_thr, cfg_var_thr;
  logic                 s_ready, done, busy;
  logic [1:0]           motion_pattern;
  logic [7:0]           anomaly_score;
  logic [ACC_W-1:0]     energy_out, var_out;
  logic [DW:0]          peak_mag;

  logic [ACC_S-1:0]     cfg_energy_thr_s, cfg_var_thr_s;
  logic                 s_ready_s, done_s, busy_s;
  logic [1:0]           motion_pattern_s;
  logic [7:0]           anomaly_score_s;
  logic [ACC_S-1:0]     energy_out_s, var_out_s;
  logic [DW:0]          peak_mag_s;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NUM_CH*DW-1:0] win_q [WIN_LEN];
  longint exp_energy, exp_var, exp_peak;
  int     exp_pat, exp_score;

  always #5 clk = ~clk;

  motion_anomaly_engine #(.NUM_CH(NUM_CH), .DW(DW), .WIN_LEN(WIN_LEN), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .cfg_mag_thr(cfg_mag_thr),
    .cfg_energy_thr(cfg_energy_thr), .cfg_var_thr(cfg_var_thr),
    .motion_pattern(motion_pattern), .anomaly_score(anomaly_score),
    .energy_out(energy_out), .var_out(var_out), .peak_mag(peak_mag),
    .done(done), .busy(busy)
  );

  motion_anomaly_engine #(.NUM_CH(NUM_CH), .DW(DW), .WIN_LEN(WIN_LEN), .ACC_W(ACC_S)) dut_s (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data), .cfg_mag_thr(cfg_mag_thr),
    .cfg_energy_thr(cfg_energy_thr_s), .cfg_var_thr(cfg_var_thr_s),
    .motion_pattern(motion_pattern_s), .anomaly_score(anomaly_score_s),
    .energy_out(energy_out_s), .var_out(var_out_s), .peak_mag(peak_mag_s),
    .done(done_s), .busy(busy_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint mag_of(input logic [DW-1:0] v);
    longint s;
    s = longint'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  // Window statistics straight from the definitions: sums of |x|, counts, max, clamp.
  task automatic model_window(input longint acc_max, output longint e, output longint v,
                              output longint pk);
    longint m;
    e = 0; v = 0; pk = 0;
    for (int i = 0; i < WIN_LEN; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m = mag_of(win_q[i][c*DW +: DW]);
        e += m;
        if (m > longint'(cfg_mag_thr)) v++;
        if (m > pk) pk = m;
      end
    end
    if (e > acc_max) e = acc_max;
    if (v > acc_max) v = acc_max;
  endtask

  task automatic classify(input longint e, input longint v, input longint etr,
                          input longint vtr, output int pat, output int score);
    if (e > etr)      begin pat = 3; score = 95; end
    else if (v > vtr) begin pat = 2; score = 70; end
    else              begin pat = 1; score = 20; end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; s_valid = 1'b0;
    s_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Single-shot window over win_q; optional valid gaps and ignored start pokes.
  task automatic run_window(input bit gaps, input bit poke_start);
    longint e, v, pk;
    int idx, guard, lat;
    bit rdy;
    model_window((longint'(1) << ACC_W) - 1, e, v, pk);
    classify(e, v, longint'(cfg_energy_thr), longint'(cfg_var_thr), exp_pat, exp_score);
    exp_energy = e;
    exp_var    = v;
`ifdef MOTION_PEAK_EN
    exp_peak   = pk;
`else
    exp_peak   = 0;
`endif
    start = 1'b1; continuous = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    idx = 0; guard = 0;
    while (idx < WIN_LEN && guard < 200) begin
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data  = s_valid ? win_q[idx] : {16'($urandom), 32'($urandom)};
      start   = poke_start && ($urandom_range(0, 3) == 0);
      rdy     = s_ready;
      @(posedge clk); #1;
      if (s_valid && rdy) idx++;
      guard++;
    end
    s_valid = 1'b0; start = 1'b0;
    check("accepts", idx, WIN_LEN);
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_latency", lat, 2);
    check("energy_out", energy_out, exp_energy);
    check("var_out", var_out, exp_var);
    check("pattern", motion_pattern, exp_pat);
    check("score", anomaly_score, exp_score);
    check("peak_mag", peak_mag, exp_peak);
    check("busy_in_result", busy, 1);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_cleared", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint e, v, pk;
    int saw;
    cfg_mag_thr = '0; cfg_energy_thr = '0; cfg_var_thr = '0;
    cfg_energy_thr_s = 17'h1FFFE; cfg_var_thr_s = 17'h1FFFF;
    do_reset();

    // Reset state
    check("rst_pattern", motion_pattern, 0);
    check("rst_score", anomaly_score, 0);
    check("rst_energy", energy_out, 0);
    check("rst_var", var_out, 0);
    check("rst_peak", peak_mag, 0);
    check("rst_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // All-zero window, thresholds 0
    for (int i = 0; i < WIN_LEN; i++) win_q[i] = '0;
    run_window(1'b0, 1'b0);

    // {-5, 3, 0}: energy 32 against thresholds 31 and 32
    for (int i = 0; i < WIN_LEN; i++) win_q[i] = {16'h0000, 16'h0003, 16'hFFFB};
    cfg_var_thr = '1; cfg_energy_thr = 32'd31;
    run_window(1'b0, 1'b0);
    check("dir_energy32", energy_out, 32);
    check("dir_pat_hi", motion_pattern, 3);
    cfg_energy_thr = 32'd32;
    run_window(1'b0, 1'b0);
    check("dir_pat_strict", motion_pattern, 1);

    // Count-driven erratic classification
    for (int i = 0; i < WIN_LEN; i++) win_q[i] = {16'h0000, 16'h0000, 16'h2000};
    cfg_mag_thr = 16'h1000; cfg_energy_thr = '1; cfg_var_thr = 32'd3;
    run_window(1'b0, 1'b0);
    check("dir_var4", var_out, 4);
    check("dir_pat_err", motion_pattern, 2);
    check("dir_score70", anomaly_score, 70);

    // Most negative code on every channel; 17-bit instance saturates
    for (int i = 0; i < WIN_LEN; i++) win_q[i] = {16'h8000, 16'h8000, 16'h8000};
    cfg_mag_thr = 16'h7FFF; cfg_energy_thr = '1; cfg_var_thr = 32'd11;
    run_window(1'b0, 1'b0);
    check("sat_main_energy", energy_out, 64'd393216);
    check("sat_energy", energy_out_s, 64'h1FFFF);
    check("sat_var", var_out_s, 12);
    check("sat_pattern", motion_pattern_s, 3);
`ifdef MOTION_PEAK_EN
    check("sat_peak", peak_mag_s, 64'h08000);
`else
    check("sat_peak", peak_mag_s, 0);
`endif

    // Abort after two accepts: outputs hold, no done, next window starts clean
    for (int i = 0; i < WIN_LEN; i++) win_q[i] = {16'h0100, 16'hFF00, 16'h0001};
    start = 1'b1; s_valid = 1'b1; s_data = 48'h7FFF_7FFF_7FFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ready", s_ready, 0);
    check("abort_energy_hold", energy_out, exp_energy);
    check("abort_var_hold", var_out, exp_var);
    check("abort_pattern_hold", motion_pattern, exp_pat);
    check("abort_peak_hold", peak_mag, exp_peak);
    saw = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) saw = 1;
    end
    check("abort_no_done", saw, 0);
    cfg_mag_thr = 16'h0080; cfg_energy_thr = 32'd100; cfg_var_thr = 32'd1;
    run_window(1'b0, 1'b0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_ready", s_ready, 0);

    // Randomized windows against the model
    for (int w = 0; w < 30; w++) begin
      int kind, sel;
      kind = $urandom_range(0, 2);
      for (int i = 0; i < WIN_LEN; i++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          logic [15:0] val;
          int sv;
          case (kind)
            0: begin sv = int'($urandom_range(0, 16)) - 8; val = 16'(sv); end
            1: val = 16'($urandom);
            default: begin
              sel = $urandom_range(0, 3);
              val = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'h7FFF :
                    (sel == 2) ? 16'hFFFF : 16'h0001;
            end
          endcase
          win_q[i][c*DW +: DW] = val;
        end
      end
      cfg_mag_thr = (kind == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom);
      model_window((longint'(1) << ACC_W) - 1, e, v, pk);
      sel = $urandom_range(0, 2);
      cfg_energy_thr = (sel == 0 && e > 0) ? 32'(e - 1) : (sel == 1) ? 32'(e) : 32'($urandom);
      sel = $urandom_range(0, 2);
      cfg_var_thr = (sel == 0 && v > 0) ? 32'(v - 1) : (sel == 1) ? 32'(v) :
                    32'($urandom_range(0, 16));
      run_window(1'b1, 1'b1);
    end

    // Continuous mode: done at cycles 6 and 12, two not-ready cycles between windows
    cfg_mag_thr = '1; cfg_energy_thr = '0; cfg_var_thr = '1;
    start = 1'b1; continuous = 1'b1; s_valid = 1'b1; s_data = 48'h0000_0000_0001;
    @(posedge clk); #1;
    start = 1'b0; continuous = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check("cont_done", done, (c == 6 || c == 12));
      check("cont_ready", s_ready, ((c % 6) >= 1 && (c % 6) <= 4));
      if (c == 6) begin
        check("cont_energy", energy_out, 4);
        check("cont_pattern", motion_pattern, 3);
      end
      if (c < 12) begin
        @(posedge clk); #1;
      end
    end
    check("cont_busy", busy, 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    check("midrst_pattern", motion_pattern, 0);
    check("midrst_score", anomaly_score, 0);
    check("midrst_energy", energy_out, 0);
    check("midrst_var", var_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", s_ready, 0);
    check("midrst_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
